// File: rtl/hyperbus_rwds_responder.sv
// hyperbus_rwds_responder
// Device-side HyperBus responder. It captures the 48-bit command-address,
// signals single or double initial latency on RWDS while CA is on the bus,
// counts the latency and then streams read words from a valid/ready source
// as DDR bytes (hi byte with RWDS=1, lo byte with RWDS=0). Writes are
// passive. One clk_i cycle is one hyper_ck edge.
//
// Handshake: a read word moves when rd_valid_i and rd_ready_o are both high
// at a rising clk_i edge. rd_ready_o never depends on rd_valid_i.
//
// Ports:
//   clk_i, rst_ni          edge-rate clock, synchronous active-low reset
//   cfg_latency_i [3:0]    initial latency (0..2 clamped to 3)
//   cfg_fixed_latency_i    force double latency
//   refresh_busy_i         refresh collision, double latency
//   hyper_cs_ni            chip select (active low, clk_i domain)
//   hyper_dq_i [7:0]       CA byte input
//   hyper_dq_o [7:0]       read byte output, hyper_dq_oe_o its enable
//   hyper_rwds_o           RWDS value, hyper_rwds_oe_o its enable
//   ca_o [47:0]            captured CA, ca_valid_o one-cycle completion pulse
//   rd_data_i [15:0]       read word ([15:8] sent first)
//   rd_valid_i, rd_ready_o read word handshake
//   latency_2x_o           double-latency flag of current/last transaction
module hyperbus_rwds_responder (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  cfg_latency_i,
  input  logic        cfg_fixed_latency_i,
  input  logic        refresh_busy_i,
  input  logic        hyper_cs_ni,
  input  logic [7:0]  hyper_dq_i,
  output logic [7:0]  hyper_dq_o,
  output logic        hyper_dq_oe_o,
  output logic        hyper_rwds_o,
  output logic        hyper_rwds_oe_o,
  output logic [47:0] ca_o,
  output logic        ca_valid_o,
  input  logic [15:0] rd_data_i,
  input  logic        rd_valid_i,
  output logic        rd_ready_o,
  output logic        latency_2x_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CA,
    S_LATENCY,
    S_READ,
    S_WRITE
  } state_t;

  state_t      state;
  logic [2:0]  byte_idx;
  logic [5:0]  lat_cnt;
  logic [7:0]  lo_byte;
  logic        ready_q;

  // Latency decode, only used at t0.
  logic       double_lat;
  logic [3:0] lat_l;
  logic [5:0] lat_preset;

  always_comb begin
    double_lat = cfg_fixed_latency_i | refresh_busy_i;
    lat_l      = (cfg_latency_i < 4'd3) ? 4'd3 : cfg_latency_i;
    // LATENCY lasts 2*L*m-2 cycles; the counter runs from that minus one
    // down to zero.
    if (double_lat) lat_preset = {lat_l, 2'b00} - 6'd3;
    else            lat_preset = {1'b0, lat_l, 1'b0} - 6'd3;
  end

  assign rd_ready_o = ready_q & ~hyper_cs_ni;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state           <= S_IDLE;
      byte_idx        <= '0;
      lat_cnt         <= '0;
      lo_byte         <= '0;
      ready_q         <= 1'b0;
      ca_o            <= '0;
      ca_valid_o      <= 1'b0;
      latency_2x_o    <= 1'b0;
      hyper_dq_o      <= '0;
      hyper_dq_oe_o   <= 1'b0;
      hyper_rwds_o    <= 1'b0;
      hyper_rwds_oe_o <= 1'b0;
    end else begin
      ca_valid_o <= 1'b0;
      if (hyper_cs_ni) begin
        // CS high ends any transaction; a partial CA is simply dropped.
        state           <= S_IDLE;
        ready_q         <= 1'b0;
        hyper_dq_oe_o   <= 1'b0;
        hyper_rwds_o    <= 1'b0;
        hyper_rwds_oe_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            ca_o            <= {40'd0, hyper_dq_i};
            latency_2x_o    <= double_lat;
            lat_cnt         <= lat_preset;
            byte_idx        <= 3'd1;
            hyper_rwds_oe_o <= 1'b1;
            hyper_rwds_o    <= double_lat;
            hyper_dq_oe_o   <= 1'b0;
            state           <= S_CA;
          end
          S_CA: begin
            // Shift register: byte 0 ends up in [47:40] after six bytes.
            ca_o <= {ca_o[39:0], hyper_dq_i};
            if (byte_idx == 3'd5) begin
              ca_valid_o   <= 1'b1;
              hyper_rwds_o <= 1'b0;
              // ca_o[39] holds CA[47] before the final shift.
              if (ca_o[39]) begin
                state <= S_LATENCY;
              end else begin
                hyper_rwds_oe_o <= 1'b0;
                state           <= S_WRITE;
              end
            end else begin
              byte_idx <= byte_idx + 3'd1;
            end
          end
          S_LATENCY, S_READ: begin
            if (ready_q) begin
              // Ready slot (last LATENCY cycle or READ lo/stall-2 cycle).
              state         <= S_READ;
              ready_q       <= 1'b0;
              hyper_dq_oe_o <= 1'b1;
              if (rd_valid_i) begin
                hyper_dq_o   <= rd_data_i[15:8];
                lo_byte      <= rd_data_i[7:0];
                hyper_rwds_o <= 1'b1;
              end else begin
                hyper_rwds_o <= 1'b0;
              end
            end else if (state == S_LATENCY) begin
              if (lat_cnt == 6'd1) ready_q <= 1'b1;
              lat_cnt <= lat_cnt - 6'd1;
            end else begin
              // Hi cycle (RWDS=1) is followed by the lo byte; a stall-1
              // cycle (RWDS=0) keeps DQ as is.
              ready_q <= 1'b1;
              if (hyper_rwds_o) begin
                hyper_dq_o   <= lo_byte;
                hyper_rwds_o <= 1'b0;
              end
            end
          end
          S_WRITE: begin
            hyper_dq_oe_o   <= 1'b0;
            hyper_rwds_oe_o <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hyperbus_rwds_responder.sv
// Testbench for hyperbus_rwds_responder: randomized stimulus against a
// cycle-offset reference model derived from the transaction timeline
// (CA bytes, latency window of 2*L*m-2 cycles, ready slots every two cycles).
module tb_hyperbus_rwds_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  cfg_latency;
  logic        cfg_fixed;
  logic        refresh_busy;
  logic        hyper_cs_n;
  logic [7:0]  hyper_dq;
  logic [7:0]  dq_out;
  logic        dq_oe;
  logic        rwds;
  logic        rwds_oe;
  logic [47:0] ca;
  logic        ca_valid;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        lat2x;

  int n_cmp = 0;
  int n_mis = 0;

  logic [15:0] exp_q[$];
  logic [15:0] src_q[$];
  logic [7:0]  exp_dq_last = 8'h00;
  logic        exp_l2x = 1'b0;

  hyperbus_rwds_responder dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .cfg_latency_i       (cfg_latency),
    .cfg_fixed_latency_i (cfg_fixed),
    .refresh_busy_i      (refresh_busy),
    .hyper_cs_ni         (hyper_cs_n),
    .hyper_dq_i          (hyper_dq),
    .hyper_dq_o          (dq_out),
    .hyper_dq_oe_o       (dq_oe),
    .hyper_rwds_o        (rwds),
    .hyper_rwds_oe_o     (rwds_oe),
    .ca_o                (ca),
    .ca_valid_o          (ca_valid),
    .rd_data_i           (rd_data),
    .rd_valid_i          (rd_valid),
    .rd_ready_o          (rd_ready),
    .latency_2x_o        (lat2x)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One transaction from t0 (iteration k=0) until one cycle after CS rises.
  // Iteration k drives the inputs of cycle t0+k and checks its outputs.
  task automatic run_txn(input string name, input logic [47:0] ca_in,
                         input int cfg_l, input bit fixed, input bit refresh,
                         input logic [15:0] first_word, input bit rand_valid,
                         input int drop_slot, input int cs_at, input int ncyc);
    int lat_l, lat_end, cs_raise, slot;
    bit m2, is_rd, rdy_slot, cs_now, acc_now, acc1, acc2, hs;
    logic [15:0] cur, w;
    logic e_roe, e_rwds, e_doe, e_rdy, e_cav;
    logic [7:0] e_dq;
    logic [4:0] obs_c, exp_c;
    lat_l    = (cfg_l < 3) ? 3 : cfg_l;
    m2       = fixed | refresh;
    is_rd    = ca_in[47];
    lat_end  = 3 + 2 * lat_l * (m2 ? 2 : 1);
    cs_raise = (cs_at < 0) ? ncyc : cs_at;
    src_q.delete();
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      w = (i == 0) ? first_word : 16'($urandom);
      src_q.push_back(w);
      exp_q.push_back(w);
    end
    slot = 0; acc1 = 0; acc2 = 0; cur = '0;
    for (int k = 0; k <= cs_raise + 1; k++) begin
      cs_now     = (k >= cs_raise);
      hyper_cs_n = cs_now;
      hyper_dq   = (k < 6) ? ca_in[47 - 8 * k -: 8] : 8'($urandom);
      if (k == 0) begin
        cfg_latency  = 4'(cfg_l);
        cfg_fixed    = fixed;
        refresh_busy = refresh;
      end else begin
        cfg_latency  = 4'($urandom_range(0, 15));
        cfg_fixed    = 1'($urandom);
        refresh_busy = 1'($urandom);
      end
      rdy_slot = is_rd && (k >= lat_end) && (((k - lat_end) % 2) == 0) && !cs_now;
      if (rdy_slot) begin
        if (slot == drop_slot) rd_valid = 1'b0;
        else if (rand_valid)   rd_valid = ($urandom_range(0, 3) != 0);
        else                   rd_valid = 1'b1;
        slot++;
      end else begin
        rd_valid = 1'($urandom);
      end
      rd_data = (src_q.size() > 0) ? src_q[0] : 16'hdead;
      #1;
      e_roe = 0; e_rwds = 0; e_doe = 0; e_cav = 0; e_dq = exp_dq_last;
      e_rdy = rdy_slot;
      if (k > cs_raise || k == 0) begin
        e_roe = 0;
      end else if (k <= 5) begin
        e_roe = 1; e_rwds = m2;
      end else if (!is_rd) begin
        e_cav = (k == 6);
      end else if (k <= lat_end) begin
        e_roe = 1; e_cav = (k == 6);
      end else begin
        e_roe = 1; e_doe = 1;
        if (((k - lat_end) % 2) == 1) begin
          if (acc1) begin e_dq = cur[15:8]; e_rwds = 1; end
        end else if (acc2) begin
          e_dq = cur[7:0];
        end
      end
      if (k >= 1) exp_l2x = m2;
      obs_c = {rwds_oe, dq_oe, rd_ready, ca_valid, lat2x};
      exp_c = {e_roe, e_doe, e_rdy, e_cav, exp_l2x};
      n_cmp++;
      if (obs_c !== exp_c) begin
        n_mis++;
        $display("FAIL %s ctrl t0+%0d {rwds_oe,dq_oe,ready,ca_valid,lat2x}: got %b want %b",
                 name, k, obs_c, exp_c);
      end
      if (e_roe) begin
        n_cmp++;
        if (rwds !== e_rwds) begin
          n_mis++;
          $display("FAIL %s rwds t0+%0d: got %b want %b", name, k, rwds, e_rwds);
        end
      end
      if (e_doe) begin
        n_cmp++;
        if (dq_out !== e_dq) begin
          n_mis++;
          $display("FAIL %s dq t0+%0d: got %h want %h", name, k, dq_out, e_dq);
        end
        exp_dq_last = e_dq;
      end
      if (e_cav) begin
        n_cmp++;
        if (ca !== ca_in) begin
          n_mis++;
          $display("FAIL %s ca_o t0+%0d: got %h want %h", name, k, ca, ca_in);
        end
      end
      acc_now = rdy_slot && rd_valid;
      if (acc_now) cur = exp_q.pop_front();
      hs = rd_ready && rd_valid;
      @(posedge clk);
      if (hs) w = src_q.pop_front();
      acc2 = acc1;
      acc1 = acc_now;
      #1;
    end
    n_cmp++;
    if (src_q.size() !== exp_q.size()) begin
      n_mis++;
      $display("FAIL %s words_taken: got %0d want %0d", name,
               64 - src_q.size(), 64 - exp_q.size());
    end
  endtask

  task automatic test_reset();
    logic [60:0] obs;
    rst_n = 1'b0; hyper_cs_n = 1'b1; hyper_dq = '0; rd_valid = 1'b0;
    rd_data = '0; cfg_latency = 4'd6; cfg_fixed = 1'b0; refresh_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    obs = {ca, ca_valid, lat2x, dq_out, dq_oe, rwds, rwds_oe, rd_ready};
    n_cmp++;
    if (obs !== 61'd0) begin
      n_mis++;
      $display("FAIL reset outputs: got %h want 0", obs);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_read_single();
    run_txn("read_1x", 48'hA0_0000_0000_10, 6, 0, 0, 16'h1234, 0, -1, -1, 30);
  endtask

  task automatic test_read_double();
    run_txn("read_2x", 48'hA0_0000_0000_10, 6, 0, 1, 16'h1234, 0, -1, -1, 40);
  endtask

  task automatic test_reg_write();
    run_txn("reg_write", 48'h60_0001_0000_00, 6, 0, 0, 16'h0000, 0, -1, -1, 20);
  endtask

  task automatic test_stall();
    run_txn("stall", 48'hA0_0000_0000_20, 6, 0, 0, 16'hBEEF, 0, 3, -1, 36);
  endtask

  task automatic test_cs_abort_ca();
    run_txn("abort_ca", 48'hA0_0000_0000_30, 6, 0, 0, 16'h5555, 0, -1, 3, 20);
  endtask

  task automatic test_back_to_back();
    // CS rises on a ready slot mid-READ; next transaction follows directly.
    run_txn("abort_read", 48'hA0_0000_0000_40, 6, 0, 0, 16'hCAFE, 0, -1, 19, 30);
    run_txn("after_abort", 48'hC0_0000_0000_50, 4, 1, 0, 16'h0F0F, 0, -1, -1, 30);
  endtask

  task automatic test_min_latency();
    run_txn("lat_clamp", 48'hA0_0000_0000_60, 1, 0, 0, 16'hA55A, 0, -1, -1, 20);
  endtask

  task automatic test_random();
    logic [47:0] rca;
    for (int i = 0; i < 4; i++) begin
      rca = {1'b1, 15'($urandom), 32'($urandom)};
      run_txn("random", rca, $urandom_range(0, 15), 1'($urandom), 1'($urandom),
              16'($urandom), 1, -1, -1, 90);
    end
  endtask

  task automatic test_reset_mid_latency();
    logic [47:0] rca;
    logic [60:0] obs;
    rca = 48'hA0_0000_0000_70;
    cfg_latency = 4'd6; cfg_fixed = 1'b0; refresh_busy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      hyper_cs_n = 1'b0;
      hyper_dq   = (k < 6) ? rca[47 - 8 * k -: 8] : 8'($urandom);
      rd_valid   = 1'($urandom);
      rst_n      = (k == 9) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
    end
    obs = {ca, ca_valid, lat2x, dq_out, dq_oe, rwds, rwds_oe, rd_ready};
    n_cmp++;
    if (obs !== 61'd0) begin
      n_mis++;
      $display("FAIL reset_mid_latency outputs: got %h want 0", obs);
    end
    rst_n = 1'b1;
    hyper_cs_n = 1'b1;
    @(posedge clk);
    #1;
    exp_dq_last = 8'h00;
    exp_l2x = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read_single();
    test_read_double();
    test_reg_write();
    test_stall();
    test_cs_abort_ca();
    test_back_to_back();
    test_reset_mid_latency();
    test_min_latency();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
